// File: rtl/rx_ptp_pkg.sv
// rx_ptp_pkg: constants, types and decode helpers shared by the gPTP receive parser.
package rx_ptp_pkg;

    localparam int TS_W     = 80;
    localparam int TS_BYTES = TS_W / 8;

    // Byte counter width and saturation point
    localparam logic [5:0] CNT_MAX = 6'd63;

    localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;
    localparam logic [3:0]  PTP_TRANSPORT = 4'h1;

    localparam logic [3:0] MSG_SYNC           = 4'h0;
    localparam logic [3:0] MSG_FOLLOW_UP      = 4'h8;
    localparam logic [3:0] MSG_PDELAY_REQ     = 4'h2;
    localparam logic [3:0] MSG_PDELAY_RESP    = 4'h3;
    localparam logic [3:0] MSG_PDELAY_RESP_FU = 4'hA;

    localparam int BIT_SYNC           = 0;
    localparam int BIT_FOLLOW_UP      = 1;
    localparam int BIT_PDELAY_REQ     = 2;
    localparam int BIT_PDELAY_RESP    = 3;
    localparam int BIT_PDELAY_RESP_FU = 4;

    // Byte offsets within the frame (byte 0 is the sof byte)
    localparam logic [5:0] OFS_ETYPE    = 6'd12;
    localparam logic [5:0] OFS_MSGTYPE  = 6'd14;
    localparam logic [5:0] OFS_TS_FIRST = 6'd48;
    localparam logic [5:0] OFS_TS_LAST  = 6'd57;
    localparam logic [5:0] OFS_MIN_EOF  = 6'd58;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    // One pending write toward the timestamp consumer
    typedef struct packed {
        logic [7:0]      addr;
        logic [TS_W-1:0] data1;
        logic [TS_W-1:0] data2;
    } rev_wr_t;

    // One-hot write address for a supported messageType, zero if unsupported
    function automatic logic [7:0] msg_onehot(input logic [3:0] msg_type);
        logic [7:0] oh;
        oh = '0;
        case (msg_type)
            MSG_SYNC:           oh[BIT_SYNC]           = 1'b1;
            MSG_FOLLOW_UP:      oh[BIT_FOLLOW_UP]      = 1'b1;
            MSG_PDELAY_REQ:     oh[BIT_PDELAY_REQ]     = 1'b1;
            MSG_PDELAY_RESP:    oh[BIT_PDELAY_RESP]    = 1'b1;
            MSG_PDELAY_RESP_FU: oh[BIT_PDELAY_RESP_FU] = 1'b1;
            default:            oh = '0;
        endcase
        return oh;
    endfunction

    // Sync and Pdelay_Req carry no meaningful timestamp in bytes 48..57
    function automatic logic carries_ts(input logic [7:0] addr);
        return !(addr[BIT_SYNC] || addr[BIT_PDELAY_REQ]);
    endfunction

endpackage

// File: rtl/rx_ts_shift.sv
// rx_ts_shift: big-endian byte shift register collecting the carried timestamp.
module rx_ts_shift
    import rx_ptp_pkg::*;
#(
    parameter int NUM_BYTES = TS_BYTES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [7:0]             din,
    output logic [NUM_BYTES*8-1:0] q
);

    // First byte shifted in ends up in the top byte after NUM_BYTES shifts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[NUM_BYTES*8-9:0], din};
        end
    end

endmodule

// File: rtl/rx_ptp_parser.sv
// rx_ptp_parser: filters gPTP event/general messages from the MAC byte stream
// and hands {type, receive time, carried time} to a downstream consumer.
module rx_ptp_parser
    import rx_ptp_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      rx_mac_data,
    input  logic            rx_mac_vaild,
    input  logic            rx_mac_sof,
    input  logic            rx_mac_eof,
    input  logic            rx_mac_err,
    input  logic [TS_W-1:0] rx_ts,
    output logic            rx_rev_wr_vaild,
    output logic [7:0]      rx_rev_wr_addr,
    output logic [TS_W-1:0] rx_rev_wr_data1,
    output logic [TS_W-1:0] rx_rev_wr_data2,
    input  logic            rx_rev_wr_v_ready,
    output logic [15:0]     rx_drop_cnt
);

    state_t          state;
    logic [5:0]      byte_cnt;   // index of the current non-sof byte
    logic [TS_W-1:0] ts_cap;
    logic            eth_ok;     // bytes 12/13 matched the PTP ethertype so far
    logic [7:0]      msg_addr;
    logic            drop_flag;  // header rejected, waiting for eof
    rev_wr_t         wr_q;
    logic [TS_W-1:0] carried_ts;
    logic            in_frame;
    logic            sof_v;
    logic            eof_v;
    logic            ts_shift_en;
    logic            hdr_pass;
    logic [1:0]      drop_inc;
    logic [16:0]     drop_sum;

    assign in_frame = (state == ST_HDR) || (state == ST_BODY) || (state == ST_DRAIN);
    assign sof_v    = rx_mac_vaild && rx_mac_sof;
    assign eof_v    = rx_mac_vaild && rx_mac_eof && !rx_mac_sof;

    assign ts_shift_en = rx_mac_vaild && !rx_mac_sof && (state == ST_BODY) &&
                         (byte_cnt >= OFS_TS_FIRST) && (byte_cnt <= OFS_TS_LAST);

    assign hdr_pass = eth_ok && (rx_mac_data[7:4] == PTP_TRANSPORT) &&
                      (msg_onehot(rx_mac_data[3:0]) != 8'h00);

    rx_ts_shift #(.NUM_BYTES(TS_BYTES)) u_ts_shift (
        .clk      (clk),
        .reset    (reset),
        .clr      (sof_v && (state != ST_HOLD)),
        .shift_en (ts_shift_en),
        .din      (rx_mac_data),
        .q        (carried_ts)
    );

    // Number of frames that end badly this cycle (abort plus one-byte frame can give 2)
    always_comb begin
        drop_inc = 2'd0;
        if (sof_v) begin
            if (in_frame) drop_inc = drop_inc + 2'd1;
            if (state == ST_HOLD) drop_inc = drop_inc + 2'd1;
            else if (rx_mac_eof) drop_inc = drop_inc + 2'd1;
        end else if (eof_v) begin
            if ((state == ST_HDR) || (state == ST_BODY)) begin
                drop_inc = 2'd1;
            end else if ((state == ST_DRAIN) &&
                         (drop_flag || rx_mac_err || (byte_cnt < OFS_MIN_EOF))) begin
                drop_inc = 2'd1;
            end
        end
    end

    assign drop_sum = {1'b0, rx_drop_cnt} + {15'd0, drop_inc};

    // Saturating discarded-frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_drop_cnt <= '0;
        else        rx_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Frame parsing FSM; the pending write is latched on accepted eof
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            ts_cap    <= '0;
            eth_ok    <= 1'b0;
            msg_addr  <= '0;
            drop_flag <= 1'b0;
            wr_q      <= '0;
        end else if (state == ST_HOLD) begin
            // sof here is lost (counted above); only the consumer can release us
            if (rx_rev_wr_v_ready) state <= ST_IDLE;
        end else if (rx_mac_vaild) begin
            if (rx_mac_sof) begin
                ts_cap    <= rx_ts;
                byte_cnt  <= 6'd1;
                eth_ok    <= 1'b0;
                msg_addr  <= '0;
                drop_flag <= 1'b0;
                state     <= rx_mac_eof ? ST_IDLE : ST_HDR;
            end else if (in_frame) begin
                if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 6'd1;
                case (state)
                    ST_HDR: begin
                        if (rx_mac_eof) begin
                            state <= ST_IDLE;
                        end else if (byte_cnt == OFS_ETYPE) begin
                            eth_ok <= (rx_mac_data == PTP_ETHERTYPE[15:8]);
                        end else if (byte_cnt == OFS_ETYPE + 6'd1) begin
                            eth_ok <= eth_ok && (rx_mac_data == PTP_ETHERTYPE[7:0]);
                        end else if (byte_cnt == OFS_MSGTYPE) begin
                            if (hdr_pass) begin
                                msg_addr <= msg_onehot(rx_mac_data[3:0]);
                                state    <= ST_BODY;
                            end else begin
                                drop_flag <= 1'b1;
                                state     <= ST_DRAIN;
                            end
                        end
                    end
                    ST_BODY: begin
                        if (rx_mac_eof)                   state <= ST_IDLE;
                        else if (byte_cnt == OFS_TS_LAST) state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (rx_mac_eof) begin
                            if (!drop_flag && !rx_mac_err && (byte_cnt >= OFS_MIN_EOF)) begin
                                wr_q.addr  <= msg_addr;
                                wr_q.data1 <= ts_cap;
                                wr_q.data2 <= carries_ts(msg_addr) ? carried_ts : '0;
                                state      <= ST_HOLD;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Valid follows ready combinationally so the write fires on the first ready cycle
    assign rx_rev_wr_vaild = (state == ST_HOLD) && rx_rev_wr_v_ready;
    assign rx_rev_wr_addr  = wr_q.addr;
    assign rx_rev_wr_data1 = wr_q.data1;
    assign rx_rev_wr_data2 = wr_q.data2;

endmodule

// File: tb/tb_rx_ptp_parser.sv
// tb_rx_ptp_parser: randomized frames against a frame-level reference model,
// expected writes queued at eof and popped by an independent output monitor.
module tb_rx_ptp_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_mac_data;
    logic        rx_mac_vaild, rx_mac_sof, rx_mac_eof, rx_mac_err;
    logic [79:0] rx_ts;
    logic        rx_rev_wr_vaild;
    logic [7:0]  rx_rev_wr_addr;
    logic [79:0] rx_rev_wr_data1, rx_rev_wr_data2;
    logic        rdy;
    logic [15:0] rx_drop_cnt;

    always #5 clk = ~clk;

    rx_ptp_parser dut (
        .clk               (clk),
        .reset             (reset),
        .rx_mac_data       (rx_mac_data),
        .rx_mac_vaild      (rx_mac_vaild),
        .rx_mac_sof        (rx_mac_sof),
        .rx_mac_eof        (rx_mac_eof),
        .rx_mac_err        (rx_mac_err),
        .rx_ts             (rx_ts),
        .rx_rev_wr_vaild   (rx_rev_wr_vaild),
        .rx_rev_wr_addr    (rx_rev_wr_addr),
        .rx_rev_wr_data1   (rx_rev_wr_data1),
        .rx_rev_wr_data2   (rx_rev_wr_data2),
        .rx_rev_wr_v_ready (rdy),
        .rx_drop_cnt       (rx_drop_cnt)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [79:0] d1;
        logic [79:0] d2;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  fb[$];    // bytes of the frame the model is currently following
    logic [7:0]  frm[$];   // frame being transmitted
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;  // 0 always ready, 1 random, 2 never
    int          exp_drop = 0;
    bit          pending = 0;   // an accepted frame is waiting for ready
    bit          live = 0;      // model is following a frame
    bit          mon_en = 0;
    bit          use_fixed_ts = 0;
    logic [79:0] fixed_ts = '0;
    logic [79:0] ts_cap = '0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Frame verdict at eof, straight from the acceptance rules
    task automatic judge(input logic er, output logic acc);
        int         n;
        logic [7:0] b14;
        exp_t       x;
        n   = fb.size();
        acc = 1'b0;
        if (n >= 59 && !er && fb[12] == 8'h88 && fb[13] == 8'hF7) begin
            b14 = fb[14];
            if (b14[7:4] == 4'h1) begin
                case (b14[3:0])
                    4'h0:    x.addr = 8'h01;
                    4'h8:    x.addr = 8'h02;
                    4'h2:    x.addr = 8'h04;
                    4'h3:    x.addr = 8'h08;
                    4'hA:    x.addr = 8'h10;
                    default: x.addr = 8'h00;
                endcase
                if (x.addr != 8'h00) begin
                    x.d1 = ts_cap;
                    x.d2 = '0;
                    if (b14[3:0] != 4'h0 && b14[3:0] != 4'h2)
                        for (int i = 48; i < 58; i++) x.d2 = {x.d2[71:0], fb[i]};
                    expq.push_back(x);
                    acc = 1'b1;
                end
            end
        end
    endtask

    // Drive one clock of input and advance the model past that edge
    task automatic cycle(input logic v, input logic [7:0] d, input logic s,
                         input logic e, input logic er);
        logic [31:0] r0, r1, r2;
        bit          old_pend;
        logic        acc;
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        rx_mac_vaild = v; rx_mac_data = d; rx_mac_sof = s; rx_mac_eof = e; rx_mac_err = er;
        rx_ts = use_fixed_ts ? fixed_ts : {r0[15:0], r1, r2};
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = r0[31];
            default: rdy = 1'b0;
        endcase
        @(posedge clk);
        #1;
        old_pend = pending;
        acc = 1'b0;
        if (v) begin
            if (s) begin
                if (live) exp_drop++;
                if (old_pend) begin
                    live = 0;
                    exp_drop++;
                end else begin
                    live = 1;
                    fb.delete();
                    ts_cap = rx_ts;
                end
            end
            if (live) begin
                fb.push_back(d);
                if (e) begin
                    live = 0;
                    judge(er, acc);
                    if (!acc) exp_drop++;
                end
            end
        end
        if (old_pend && rdy) pending = 0;
        if (acc) pending = 1;
    endtask

    // Idle cycle; framing bits toggle randomly but are unqualified
    task automatic idle();
        logic [31:0] r;
        r = $urandom;
        cycle(1'b0, r[7:0], r[8], r[9], r[10]);
    endtask

    task automatic build_frame(input int len, input logic [7:0] hi, input logic [7:0] lo,
                               input logic [7:0] b14, input logic [79:0] cts);
        logic [31:0] r;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            r = $urandom;
            if (i == 12)                 frm.push_back(hi);
            else if (i == 13)            frm.push_back(lo);
            else if (i == 14)            frm.push_back(b14);
            else if (i >= 48 && i <= 57) frm.push_back(cts[79 - 8*(i-48) -: 8]);
            else                         frm.push_back(r[7:0]);
        end
    endtask

    // Send the first nbytes of frm; eof only if the whole frame goes out
    task automatic send_frame(input logic er, input int gap_pct, input int nbytes);
        int last;
        last = frm.size() - 1;
        for (int i = 0; i < nbytes; i++) begin
            while ($urandom_range(0, 99) < gap_pct) idle();
            cycle(1'b1, frm[i], i == 0, i == last, (i == last) ? er : 1'b0);
            use_fixed_ts = 0;
        end
    endtask

    // Output monitor: drop count every cycle, writes popped from the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("drop_cnt", {64'd0, rx_drop_cnt}, (exp_drop > 65535) ? 80'hFFFF : 80'(exp_drop));
            chk("wr_vaild", {79'd0, rx_rev_wr_vaild}, {79'd0, pending && rdy});
            if (rx_rev_wr_vaild === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("unexpected_write", 80'd1, 80'd0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("wr_addr", {72'd0, rx_rev_wr_addr}, {72'd0, mon_e.addr});
                    chk("wr_data1", rx_rev_wr_data1, mon_e.d1);
                    chk("wr_data2", rx_rev_wr_data2, mon_e.d2);
                end
            end
        end
    end

    initial begin
        int          len, nb, r, gap;
        logic [7:0]  hi, lo, b14;
        logic [31:0] a0, a1, a2;
        logic        er;

        reset = 1'b0;
        rx_mac_data = '0; rx_mac_vaild = 0; rx_mac_sof = 0; rx_mac_eof = 0; rx_mac_err = 0;
        rx_ts = '0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vaild", {79'd0, rx_rev_wr_vaild}, 80'd0);
        chk("reset_addr", {72'd0, rx_rev_wr_addr}, 80'd0);
        chk("reset_data1", rx_rev_wr_data1, 80'd0);
        chk("reset_data2", rx_rev_wr_data2, 80'd0);
        chk("reset_drop", {64'd0, rx_drop_cnt}, 80'd0);
        reset = 1'b1;
        mon_en = 1;
        repeat (2) idle();

        // Follow_Up with a known carried timestamp
        rdy_mode = 0;
        build_frame(64, 8'h88, 8'hF7, 8'h18, 80'h0000_0000_0005_3B9A_C9FF);
        send_frame(1'b0, 0, frm.size());
        repeat (3) idle();

        // Pdelay_Resp with fixed receive time
        build_frame(62, 8'h88, 8'hF7, 8'h13, 80'hA1A2_A3A4_A5A6_A7A8_A9AA);
        fixed_ts = 80'h1234; use_fixed_ts = 1;
        send_frame(1'b0, 20, frm.size());
        repeat (3) idle();

        // Wrong ethertype, unsupported type, wrong transportSpecific
        build_frame(64, 8'h08, 8'h00, 8'h10, 80'h1); send_frame(1'b0, 0, frm.size());
        build_frame(64, 8'h88, 8'hF7, 8'h1B, 80'h2); send_frame(1'b0, 0, frm.size());
        build_frame(64, 8'h88, 8'hF7, 8'h20, 80'h3); send_frame(1'b0, 0, frm.size());

        // Sync with err, Sync ending at byte 40, length boundaries 58 and 59
        build_frame(64, 8'h88, 8'hF7, 8'h10, 80'h4); send_frame(1'b1, 0, frm.size());
        build_frame(41, 8'h88, 8'hF7, 8'h10, 80'h5); send_frame(1'b0, 0, frm.size());
        build_frame(58, 8'h88, 8'hF7, 8'h1A, 80'h6); send_frame(1'b0, 0, frm.size());
        build_frame(59, 8'h88, 8'hF7, 8'h1A, 80'h7); send_frame(1'b0, 0, frm.size());
        repeat (2) idle();

        // Consumer stalled: second frame lost while the first is held
        rdy_mode = 2;
        build_frame(60, 8'h88, 8'hF7, 8'h10, 80'h8); send_frame(1'b0, 0, frm.size());
        repeat (5) idle();
        build_frame(20, 8'h88, 8'hF7, 8'h12, 80'h9); send_frame(1'b0, 0, frm.size());
        repeat (20) idle();
        rdy_mode = 0;
        repeat (3) idle();

        // Abort by a new sof mid-frame
        build_frame(64, 8'h88, 8'hF7, 8'h18, 80'hB); send_frame(1'b0, 0, 35);
        build_frame(66, 8'h88, 8'hF7, 8'h18, 80'hC); send_frame(1'b0, 0, frm.size());
        repeat (3) idle();

        // Reset at byte 30, tail of the old frame must be ignored afterwards
        build_frame(64, 8'h88, 8'hF7, 8'h13, 80'hD); send_frame(1'b0, 0, 31);
        rx_mac_vaild = 1'b0;
        #1 reset = 1'b0;
        pending = 0; live = 0; exp_drop = 0; expq.delete();
        #1;
        chk("rst_mid_vaild", {79'd0, rx_rev_wr_vaild}, 80'd0);
        chk("rst_mid_addr", {72'd0, rx_rev_wr_addr}, 80'd0);
        chk("rst_mid_data1", rx_rev_wr_data1, 80'd0);
        chk("rst_mid_data2", rx_rev_wr_data2, 80'd0);
        chk("rst_mid_drop", {64'd0, rx_drop_cnt}, 80'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 31; i < 64; i++) cycle(1'b1, frm[i], 1'b0, i == 63, 1'b0);
        build_frame(70, 8'h88, 8'hF7, 8'h1A, 80'hE); send_frame(1'b0, 0, frm.size());
        repeat (3) idle();

        // Randomized traffic
        for (int f = 0; f < 120; f++) begin
            r = $urandom_range(0, 9);
            rdy_mode = (r < 5) ? 0 : (r < 9) ? 1 : 2;
            hi = 8'h88; lo = 8'hF7;
            a0 = $urandom; a1 = $urandom; a2 = $urandom;
            case ($urandom_range(0, 9))
                0:       begin hi = 8'h08; lo = 8'h00; b14 = {4'h1, a0[3:0]}; end
                1:       b14 = {(a0[7:4] == 4'h1) ? 4'h2 : a0[7:4], a0[3:0]};
                2:       b14 = {4'h1, a0[3:0]};
                default: begin
                    case ($urandom_range(0, 4))
                        0:       b14 = 8'h10;
                        1:       b14 = 8'h18;
                        2:       b14 = 8'h12;
                        3:       b14 = 8'h13;
                        default: b14 = 8'h1A;
                    endcase
                end
            endcase
            case ($urandom_range(0, 9))
                0:       len = $urandom_range(10, 58);
                1:       len = $urandom_range(57, 59);
                default: len = $urandom_range(59, 90);
            endcase
            build_frame(len, hi, lo, b14, {a0[15:0], a1, a2});
            nb  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : len;
            er  = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 30);
            send_frame(er, gap, nb);
            repeat ($urandom_range(0, 4)) idle();
        end

        rdy_mode = 0;
        repeat (6) idle();
        chk("scoreboard_empty", 80'(expq.size()), 80'd0);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
